// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one pipelined fadd unit between two requesters.
// A tag pipeline routes each result to its owner's credit-guarded result FIFO.
module fpu_addsub_arbiter #(
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_sub,
  input  logic [31:0] req_x1_0,
  input  logic [31:0] req_x2_0,
  input  logic [31:0] req_x1_1,
  input  logic [31:0] req_x2_1,
  output logic [31:0] fadd_x1,
  output logic [31:0] fadd_x2,
  input  logic [31:0] fadd_y,
  input  logic        fadd_ovf,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_y_0,
  output logic [31:0] rsp_y_1,
  output logic [1:0]  rsp_ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic          rr;
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] occ [2];
  logic [AW-1:0] rdp [2];
  logic [AW-1:0] wrp [2];
  logic [31:0]   mem_y [2][DEPTH];
  logic          mem_o [2][DEPTH];
  logic [LAT:0]  tag_v;
  logic [LAT:0]  tag_p;

  logic [1:0]  elig;
  logic [1:0]  cand;
  logic [1:0]  grant;
  logic [1:0]  wr;
  logic [1:0]  pop;
  logic        accept;
  logic        sel_sub;
  logic [31:0] sel_x1;
  logic [31:0] sel_x2;
  logic [31:0] op_x2;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Eligibility comes only from registered credit counts, so rsp_ready never reaches req_ready.
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = (cnt[i] < DEPTH_C);
    end
    cand  = req_valid & elig;
    grant = cand;
    if (cand == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end
    req_ready = rstn ? grant : 2'b00;
    accept    = |req_ready;
  end

  always_comb begin
    sel_sub = req_ready[1] ? req_sub[1]  : req_sub[0];
    sel_x1  = req_ready[1] ? req_x1_1    : req_x1_0;
    sel_x2  = req_ready[1] ? req_x2_1    : req_x2_0;
    op_x2   = sel_sub ? {~sel_x2[31], sel_x2[30:0]} : sel_x2;
  end

  always_comb begin
    wr  = 2'b00;
    pop = 2'b00;
    for (int i = 0; i < 2; i++) begin
      wr[i]        = tag_v[LAT] && (tag_p[LAT] == 1'(i));
      rsp_valid[i] = (occ[i] != '0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      rsp_ovf[i]   = mem_o[i][rdp[i]];
    end
    rsp_y_0 = mem_y[0][rdp[0]];
    rsp_y_1 = mem_y[1][rdp[1]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fadd_x1 <= '0;
      fadd_x2 <= '0;
      tag_v   <= '0;
      tag_p   <= '0;
      rr      <= 1'b0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], accept};
      tag_p <= {tag_p[LAT-1:0], req_ready[1]};
      if (accept) begin
        fadd_x1 <= sel_x1;
        fadd_x2 <= op_x2;
        rr      <= req_ready[0];
      end
    end
  end

  // Credits count queued plus in-flight results, so a completing write always finds space.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        occ[i] <= '0;
        rdp[i] <= '0;
        wrp[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_y[i][j] <= '0;
          mem_o[i][j] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr[i]) begin
          mem_y[i][wrp[i]] <= fadd_y;
          mem_o[i][wrp[i]] <= fadd_ovf;
          wrp[i]           <= ptr_next(wrp[i]);
        end
        if (pop[i]) begin
          rdp[i] <= ptr_next(rdp[i]);
        end
        occ[i] <= occ[i] + CW'(wr[i]) - CW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(req_ready[i]) - CW'(pop[i]);
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a LAT=2 lookup-table fadd stand-in.
// Expected values are hand-computed IEEE-754 single-precision results.
module tb_fpu_addsub_arbiter;

  localparam logic [31:0] F1_0  = 32'h3F800000;
  localparam logic [31:0] F1_5  = 32'h3FC00000;
  localparam logic [31:0] F2_0  = 32'h40000000;
  localparam logic [31:0] F2_5  = 32'h40200000;
  localparam logic [31:0] F3_0  = 32'h40400000;
  localparam logic [31:0] F4_0  = 32'h40800000;
  localparam logic [31:0] FMAX  = 32'h7F7FFFFF;
  localparam logic [31:0] FINF  = 32'h7F800000;
  localparam logic [31:0] FNEG1 = 32'hBF800000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqSub;
  logic [31:0] reqX10, reqX20, reqX11, reqX21;
  logic [31:0] faddX1, faddX2;
  logic [31:0] faddY;
  logic        faddOvf;
  logic [1:0]  rspValid;
  logic [1:0]  rspReady;
  logic [31:0] rspY0, rspY1;
  logic [1:0]  rspOvf;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [32:0] addStage1 = '0;
  logic [32:0] addStage2 = '0;

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.LAT(2), .DEPTH(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_sub   (reqSub),
    .req_x1_0  (reqX10),
    .req_x2_0  (reqX20),
    .req_x1_1  (reqX11),
    .req_x2_1  (reqX21),
    .fadd_x1   (faddX1),
    .fadd_x2   (faddX2),
    .fadd_y    (faddY),
    .fadd_ovf  (faddOvf),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_y_0   (rspY0),
    .rsp_y_1   (rspY1),
    .rsp_ovf   (rspOvf)
  );

  // Stand-in adder: only the operand pairs used below have known sums.
  function automatic logic [32:0] addModel(input logic [31:0] a, input logic [31:0] b);
    if (a == F3_0 && b == FNEG1) return {F2_0, 1'b0};
    if (a == F1_5 && b == F2_5)  return {F4_0, 1'b0};
    if (a == FMAX && b == FMAX)  return {FINF, 1'b1};
    return {32'h7FC00000, 1'b0};
  endfunction

  // Two register stages give the adder its two-cycle latency.
  always @(posedge clk) begin
    addStage1 <= addModel(faddX1, faddX2);
    addStage2 <= addStage1;
  end

  assign faddY   = addStage2[32:1];
  assign faddOvf = addStage2[0];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] sub,
                               input logic [31:0] x10, input logic [31:0] x20,
                               input logic [31:0] x11, input logic [31:0] x21,
                               input logic [1:0] rdy);
    reqValid = valid;
    reqSub   = sub;
    reqX10   = x10;
    reqX20   = x20;
    reqX11   = x11;
    reqX21   = x21;
    rspReady = rdy;
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(2'b11, 2'b00, F1_5, F2_5, F3_0, F1_0, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset req_ready", 32'(reqReady), 32'h0);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset fadd_x1", faddX1, 32'h0);
    checkOutput("reset fadd_x2", faddX2, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);

    // Contention: both ports every cycle, grants alternate from port 0
    applyStimulus(2'b11, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b11);
    #1 checkOutput("contention grant 0", 32'(reqReady), 32'h1);
    @(negedge clk); #1 checkOutput("contention grant 1", 32'(reqReady), 32'h2);
    @(negedge clk); #1 checkOutput("contention grant 2", 32'(reqReady), 32'h1);
    @(negedge clk); #1 checkOutput("contention grant 3", 32'(reqReady), 32'h2);
    @(negedge clk);
    checkOutput("contention rsp_valid a", 32'(rspValid), 32'h1);
    checkOutput("contention port0 y a", rspY0, F4_0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11);
    @(negedge clk);
    checkOutput("contention rsp_valid b", 32'(rspValid), 32'h2);
    checkOutput("contention port1 y b", rspY1, F2_0);
    @(negedge clk);
    checkOutput("contention rsp_valid c", 32'(rspValid), 32'h1);
    checkOutput("contention port0 y c", rspY0, F4_0);
    @(negedge clk);
    checkOutput("contention rsp_valid d", 32'(rspValid), 32'h2);
    checkOutput("contention port1 y d", rspY1, F2_0);
    @(negedge clk);
    checkOutput("contention drained", 32'(rspValid), 32'h0);

    // Single subtraction on port 0: 3.0 - 1.0
    applyStimulus(2'b01, 2'b01, F3_0, F1_0, 32'h0, 32'h0, 2'b00);
    #1 checkOutput("sub grant", 32'(reqReady), 32'h1);
    @(negedge clk);
    checkOutput("sub fadd_x1", faddX1, F3_0);
    checkOutput("sub fadd_x2 negated", faddX2, FNEG1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("sub not yet valid +2", 32'(rspValid), 32'h0);
    @(negedge clk);
    checkOutput("sub not yet valid +3", 32'(rspValid), 32'h0);
    @(negedge clk);
    checkOutput("sub rsp_valid", 32'(rspValid), 32'h1);
    checkOutput("sub rsp_y_0", rspY0, F2_0);
    checkOutput("sub rsp_ovf", 32'(rspOvf), 32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01);
    @(negedge clk);
    checkOutput("sub popped", 32'(rspValid), 32'h0);

    // Backpressure on port 1 (rr now points at port 1)
    applyStimulus(2'b11, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b01);
    #1 checkOutput("bp grant 0", 32'(reqReady), 32'h2);
    @(negedge clk); #1 checkOutput("bp grant 1", 32'(reqReady), 32'h1);
    @(negedge clk); #1 checkOutput("bp grant 2", 32'(reqReady), 32'h2);
    @(negedge clk); #1 checkOutput("bp port1 blocked, port0 granted", 32'(reqReady), 32'h1);
    @(negedge clk);
    checkOutput("bp port1 rsp_valid", 32'(rspValid), 32'h2);
    checkOutput("bp port1 rsp_y", rspY1, F2_0);
    applyStimulus(2'b10, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b01);
    #1 checkOutput("bp blocked 4", 32'(reqReady), 32'h0);
    @(negedge clk); #1 checkOutput("bp blocked 5", 32'(reqReady), 32'h0);
    @(negedge clk); #1 checkOutput("bp blocked 6", 32'(reqReady), 32'h0);
    @(negedge clk);
    applyStimulus(2'b10, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b11);
    #1 checkOutput("bp no comb path", 32'(reqReady), 32'h0);
    @(negedge clk);
    applyStimulus(2'b10, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b01);
    #1 checkOutput("bp one credit back", 32'(reqReady), 32'h2);
    @(negedge clk); #1 checkOutput("bp blocked again 9", 32'(reqReady), 32'h0);
    @(negedge clk); #1 checkOutput("bp blocked again 10", 32'(reqReady), 32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11);
    repeat (6) @(negedge clk);
    checkOutput("bp drained", 32'(rspValid), 32'h0);

    // Overflow routed only to port 1
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h0, FMAX, FMAX, 2'b00);
    #1 checkOutput("ovf grant", 32'(reqReady), 32'h2);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    repeat (3) @(negedge clk);
    checkOutput("ovf rsp_valid", 32'(rspValid), 32'h2);
    checkOutput("ovf rsp_ovf", 32'(rspOvf), 32'h2);
    checkOutput("ovf rsp_y_1", rspY1, FINF);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);
    @(negedge clk);
    checkOutput("ovf popped", 32'(rspValid), 32'h0);

    // Reset with two operations in flight
    applyStimulus(2'b11, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b00);
    #1 checkOutput("rst pre grant 0", 32'(reqReady), 32'h1);
    @(negedge clk); #1 checkOutput("rst pre grant 1", 32'(reqReady), 32'h2);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    rstn = 1'b0;
    applyStimulus(2'b11, 2'b10, F1_5, F2_5, F3_0, F1_0, 2'b00);
    #1;
    checkOutput("rst req_ready low", 32'(reqReady), 32'h0);
    checkOutput("rst rsp_valid low", 32'(rspValid), 32'h0);
    checkOutput("rst fadd_x1 cleared", faddX1, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1 checkOutput("rst first grant port0", 32'(reqReady), 32'h1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checkOutput("rst no stale +1", 32'(rspValid), 32'h0);
    @(negedge clk); checkOutput("rst no stale +2", 32'(rspValid), 32'h0);
    @(negedge clk); checkOutput("rst no stale +3", 32'(rspValid), 32'h0);
    @(negedge clk);
    checkOutput("rst new result valid", 32'(rspValid), 32'h1);
    checkOutput("rst new result y", rspY0, F4_0);

    // Accept and dequeue together on port 0 at cnt = DEPTH-1
    applyStimulus(2'b01, 2'b00, F1_5, F2_5, 32'h0, 32'h0, 2'b01);
    #1 checkOutput("simul grant", 32'(reqReady), 32'h1);
    @(negedge clk);
    checkOutput("simul fifo popped", 32'(rspValid), 32'h0);
    #1 checkOutput("simul still eligible", 32'(reqReady), 32'h1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01);
    repeat (6) @(negedge clk);
    checkOutput("simul drained", 32'(rspValid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
